vx_arb_stream_mux: RTL and testbench

Output stage for the round-robin arbiter: it consumes the arbiter's grant and steers the winning input's payload into a registered, 2-entry output buffer. It provides per-input valid/ready handshakes upstream and a single valid/ready stream downstream. The arbiter pointer advances only on cycles where a transfer is actually accepted into the buffer. Typical uses are memory-request and writeback merge points, with one arbiter instance placed beside this block.

---
 rtl/vx_arb_stream_mux_pkg.sv | 15 +
 rtl/vx_arb_stream_mux_if.sv | 40 ++++
 rtl/vx_arb_stream_mux_skid_buf2.sv | 79 +++++++
 rtl/vx_arb_stream_mux.sv | 81 ++++++++
 tb/tb_vx_arb_stream_mux.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vx_arb_stream_mux_pkg.sv
// Shared constants and buffer state encoding for the arbiter output stage.
// Used by vx_arb_stream_mux and vx_skid_buf2 (perf counters under VX_ARB_STREAM_PERF_EN).
package vx_arb_pkg;

  localparam int unsigned ARB_STREAM_BUF_DEPTH = 2;
  localparam int unsigned ARB_PERF_CNT_W       = 32;

  // Encoding doubles as the occupancy count (0, 1, 2).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } arb_buf_state_e;

endpackage

// File: rtl/vx_arb_stream_mux_if.sv
// Upstream, arbiter and downstream handshake bundle for vx_arb_stream_mux.
// master = the mux itself, slave = the surrounding environment.
interface vx_arb_stream_mux_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 32,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
);

  logic [NUM_INPUTS-1:0]       valid_in;
  logic [NUM_INPUTS*DATAW-1:0] data_in;
  logic [NUM_INPUTS-1:0]       ready_in;

  logic [NUM_INPUTS-1:0]       arb_requests;
  logic [SEL_W-1:0]            arb_grant_index;
  logic [NUM_INPUTS-1:0]       arb_grant_onehot;
  logic                        arb_grant_valid;
  logic                        arb_grant_ready;

  logic                        valid_out;
  logic [DATAW-1:0]            data_out;
  logic [SEL_W-1:0]            sel_out;
  logic                        ready_out;

  modport master (
    input  valid_in, data_in,
    input  arb_grant_index, arb_grant_onehot, arb_grant_valid,
    input  ready_out,
    output ready_in, arb_requests, arb_grant_ready,
    output valid_out, data_out, sel_out
  );

  modport slave (
    output valid_in, data_in,
    output arb_grant_index, arb_grant_onehot, arb_grant_valid,
    output ready_out,
    input  ready_in, arb_requests, arb_grant_ready,
    input  valid_out, data_out, sel_out
  );

endinterface

// File: rtl/vx_arb_stream_mux_skid_buf2.sv
// Two-entry in-order buffer (head/tail registers) behind the arbiter mux.
// space depends only on registered state so upstream ready never sees ready_out.
module vx_skid_buf2
  import vx_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             space,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  arb_buf_state_e   state_q, state_d;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             head_load, head_from_tail, tail_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FULL never sees push: the caller gates push with space.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = HALF;
          head_load = 1'b1;
        end
      end
      HALF: begin
        if (push && pop) begin
          head_load = 1'b1;
        end else if (push) begin
          state_d   = FULL;
          tail_load = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = HALF;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (head_load) begin
      head_q <= din;
    end else if (head_from_tail) begin
      head_q <= tail_q;
    end
    if (tail_load) begin
      tail_q <= din;
    end
  end

  assign space = (state_q != FULL);
  assign valid = (state_q != EMPTY);
  assign dout  = head_q;

endmodule

// File: rtl/vx_arb_stream_mux.sv
// Arbiter output stage: steers the granted input into a 2-entry registered buffer.
// Define VX_ARB_STREAM_PERF_EN to add perf_stalls/perf_xfers counters.
module vx_arb_stream_mux
  import vx_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 32,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_arb_stream_mux_if.master       bus
`ifdef VX_ARB_STREAM_PERF_EN
  ,
  output logic [ARB_PERF_CNT_W-1:0] perf_stalls,
  output logic [ARB_PERF_CNT_W-1:0] perf_xfers
`endif
);

  localparam int unsigned ENTRY_W = DATAW + SEL_W;

  logic               space;
  logic               push;
  logic               pop;
  logic               buf_valid;
  logic [DATAW-1:0]   grant_data;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

  assign bus.arb_requests    = bus.valid_in;
  assign push                = bus.arb_grant_valid & space;
  assign bus.arb_grant_ready = push;
  assign bus.ready_in        = bus.arb_grant_onehot & {NUM_INPUTS{space}};
  assign pop                 = buf_valid & bus.ready_out;

  // The grant index alone selects the payload; the one-hot only gates ready_in.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (bus.arb_grant_index == SEL_W'(i)) begin
        grant_data = bus.data_in[i*DATAW +: DATAW];
      end
    end
  end

  assign entry_in = {bus.arb_grant_index, grant_data};

  vx_skid_buf2 #(
    .WIDTH (ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry_in),
    .space (space),
    .valid (buf_valid),
    .dout  (entry_out)
  );

  assign bus.valid_out = buf_valid;
  assign bus.data_out  = entry_out[DATAW-1:0];
  assign bus.sel_out   = entry_out[ENTRY_W-1:DATAW];

`ifdef VX_ARB_STREAM_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= '0;
      perf_xfers  <= '0;
    end else begin
      if ((|bus.valid_in) && !space) begin
        perf_stalls <= perf_stalls + 1'b1;
      end
      if (push) begin
        perf_xfers <= perf_xfers + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_arb_stream_mux.sv
// Directed bench for vx_arb_stream_mux with a round-robin arbiter model alongside.
// Perf counter steps are compiled in when VX_ARB_STREAM_PERF_EN is defined.
module tb_vx_arb_stream_mux;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  vx_arb_stream_mux_if #(.NUM_INPUTS(NI), .DATAW(DW), .SEL_W(SW)) bus ();

`ifdef VX_ARB_STREAM_PERF_EN
  logic [31:0] perf_stalls;
  logic [31:0] perf_xfers;
`endif

  vx_arb_stream_mux #(
    .NUM_INPUTS (NI),
    .DATAW      (DW),
    .SEL_W      (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef VX_ARB_STREAM_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_xfers  (perf_xfers)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter: pointer moves past the winner only on arb_grant_ready.
  logic [1:0] rr_ptr;
  logic [1:0] g_idx;
  logic       g_valid;

  always_comb begin
    g_valid = 1'b0;
    g_idx   = 2'd0;
    for (int k = 0; k < NI; k++) begin
      if (!g_valid && bus.arb_requests[2'(rr_ptr + 2'(k))]) begin
        g_valid = 1'b1;
        g_idx   = 2'(rr_ptr + 2'(k));
      end
    end
  end

  assign bus.arb_grant_valid  = g_valid;
  assign bus.arb_grant_index  = g_idx;
  assign bus.arb_grant_onehot = g_valid ? (4'b0001 << g_idx) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (bus.arb_grant_ready) begin
      rr_ptr <= g_idx + 2'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < NI; i++) begin
      bus.data_in[i*DW +: DW] = base + 32'(i);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel, input logic [31:0] data);
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
    chk({tag, ".sel"},   32'(bus.sel_out),   32'(sel));
    chk({tag, ".data"},  bus.data_out,       data);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held 2 cycles with every input requesting, then free-running fairness.
    reset         = 1'b1;
    bus.valid_in  = 4'b1111;
    bus.ready_out = 1'b1;
    set_data(32'hA0);
    tick();
    tick();
    chk("rst.valid", 32'(bus.valid_out), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("fair", 2'(k % 4), 32'hA0 + 32'(k % 4));
    end

    // Backpressure: two entries accepted, then pointer must hold on input 2.
    reset         = 1'b1;
    bus.valid_in  = 4'b0000;
    bus.ready_out = 1'b0;
    tick();
    tick();
    chk("bp.rst", 32'(bus.valid_out), 32'd0);
    reset        = 1'b0;
    bus.valid_in = 4'b1111;
    #1;
    chk("bp.rdy0",  32'(bus.ready_in),        32'h1);
    chk("bp.gr0",   32'(bus.arb_grant_ready), 32'd1);
    tick();
    chk_out("bp.e1", 2'd0, 32'hA0);
    chk("bp.rdy1",  32'(bus.ready_in),        32'h2);
    tick();
    chk_out("bp.full", 2'd0, 32'hA0);
    chk("bp.rdyF",  32'(bus.ready_in),        32'h0);
    chk("bp.grF",   32'(bus.arb_grant_ready), 32'd0);
    tick();
    chk_out("bp.hold", 2'd0, 32'hA0);
    chk("bp.rdyH",  32'(bus.ready_in),        32'h0);
    bus.ready_out = 1'b1;
    #1;
    chk("bp.nocomb", 32'(bus.ready_in),       32'h0);
    tick();
    chk_out("bp.o1", 2'd1, 32'hA1);
    chk("bp.rdy2",  32'(bus.ready_in),        32'h4);
    chk("bp.gr2",   32'(bus.arb_grant_ready), 32'd1);
    tick();
    chk_out("bp.o2", 2'd2, 32'hA2);
    tick();
    chk_out("bp.o3", 2'd3, 32'hA3);
    tick();
    chk_out("bp.o0", 2'd0, 32'hA0);

    // Sparse requests.
    reset         = 1'b1;
    bus.valid_in  = 4'b0000;
    bus.ready_out = 1'b1;
    set_data(32'hC0);
    tick();
    tick();
    reset        = 1'b0;
    bus.valid_in = 4'b0100;
    #1;
    chk("sp.rdy2", 32'(bus.ready_in),        32'h4);
    chk("sp.gr2",  32'(bus.arb_grant_ready), 32'd1);
    tick();
    chk_out("sp.s2", 2'd2, 32'hC2);
    bus.valid_in = 4'b1001;
    #1;
    chk("sp.rdy3", 32'(bus.ready_in), 32'h8);
    tick();
    chk_out("sp.s3", 2'd3, 32'hC3);
    bus.valid_in = 4'b0001;
    tick();
    chk_out("sp.s0", 2'd0, 32'hC0);
    bus.valid_in = 4'b0000;
    tick();
    chk("sp.drain", 32'(bus.valid_out), 32'd0);

    // Reset while FULL discards both entries.
    bus.ready_out = 1'b0;
    bus.valid_in  = 4'b1111;
    tick();
    tick();
    chk("rf.valid", 32'(bus.valid_out), 32'd1);
    chk("rf.rdy",   32'(bus.ready_in),  32'h0);
    reset        = 1'b1;
    bus.valid_in = 4'b0000;
    tick();
    chk("rf.rst", 32'(bus.valid_out), 32'd0);
    reset         = 1'b0;
    bus.ready_out = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rf.stale", 32'(bus.valid_out), 32'd0);
    end
    bus.valid_in = 4'b0010;
    tick();
    chk_out("rf.fresh", 2'd1, 32'hC1);
    bus.valid_in = 4'b0000;

`ifdef VX_ARB_STREAM_PERF_EN
    // Two pushes fill the buffer, then five stalled cycles.
    reset         = 1'b1;
    bus.ready_out = 1'b0;
    tick();
    tick();
    chk("pf.st0", perf_stalls, 32'd0);
    chk("pf.xf0", perf_xfers,  32'd0);
    reset        = 1'b0;
    bus.valid_in = 4'b0011;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    chk("pf.stalls", perf_stalls, 32'd5);
    chk("pf.xfers",  perf_xfers,  32'd2);
    chk_out("pf.head", 2'd0, 32'hC0);
    bus.valid_in = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
